mod_inverse: RTL
================

# mod_inverse

Parametrised modular-inverse engine for RSA key generation: given `a` and modulus `m`, computes `d` with (a·d) mod m = 1 using the iterative extended Euclidean algorithm. It sits after public-exponent selection and produces the private exponent `d` from `e` and φ(n). Latency is bounded by the operand width. If no inverse exists (gcd ≠ 1, or m < 2), the block terminates and reports failure.

## Interface
- `WIDTH`, 8: bit width of `a`, `m` and `out`; legal range 4–32.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  operand (e.g. public exponent), unsigned.
- `m`  in  WIDTH  modulus (e.g. φ(n)), unsigned.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  valid with `done`; held after it. 1 means an inverse exists.
- `out`  out  WIDTH  inverse in [1, m−1] when `found`; 0 otherwise. Held until the next accepted `start`.

## Operation
- Reset: state IDLE; `busy`, `done`, `found` and `out` are 0; all working registers are 0.
- Working registers: unsigned `r0`, `r1` (WIDTH bits); signed `t0`, `t1` (WIDTH+2 bits, two's complement); quotient `q` (WIDTH bits).
- IDLE: when `start` = 1, latch r0←m, r1←a, t0←0, t1←1. Go to LOOP.
- LOOP: if m_latched < 2 → FINAL with failure. Else if r1 = 0 → FINAL. Else pulse `div_start` with (r0, r1) → DIV.
- DIV: wait for `div_done`. Capture q and remainder rem → UPDATE.
- UPDATE: r0←r1, r1←rem; t0←t1, t1←t0 − q·t1. The product is computed at 2·WIDTH+2 bits and truncated to WIDTH+2 bits, which is exact because |t| ≤ m. Then → LOOP.
- FINAL: if r0 = 1 and m ≥ 2: `found`←1, `out`←(t0 < 0 ? t0 + m : t0) truncated to WIDTH bits. Otherwise `found`←0 and `out`←0. Assert `done`, → IDLE.
- `a` ≥ m needs no special case: the first iteration yields q = 0 and swaps the operands.
- a = 0: gcd = m ≠ 1, so `found` = 0.
- `start` while not in IDLE is ignored. Inputs are not sampled after acceptance.
- `start` held high in IDLE in the same cycle `done` is asserted (i.e., the first IDLE cycle after done): a new operation is accepted on that cycle.
- Asserting `rst_n` low mid-operation aborts immediately to the reset state. No `done` is produced.

## Timing
- Divider: `div_done` pulses exactly WIDTH cycles after the `div_start` cycle.
- One Euclid iteration costs WIDTH+2 cycles (LOOP 1 + DIV WIDTH + UPDATE 1).
- Latency from the accepting edge to `done` high is 2 + k·(WIDTH+2) cycles, where k is the number of iterations with r1 ≠ 0. For m < 2, latency is 2.
- k ≤ ⌈1.45·WIDTH⌉ + 1, so the worst case is bounded and the block always terminates.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `rsa_pkg`:
  - state enum {IDLE, LOOP, DIV, UPDATE, FINAL};
  - localparam `TW = WIDTH+2`;
  - shared with other RSA blocks.
- Sub-module `seq_divider`:
  - parameter WIDTH; ports clk, rst_n, div_start, dividend, divisor, quotient, remainder, div_done;
  - restoring division, one quotient bit per cycle;
  - divisor is never 0 when started.
- Top level: FSM, Euclid registers and a single multiplier for q·t1.

## Test plan
- WIDTH=8, a=3, m=7 → `done` after 22 cycles (k=2), `found`=1, `out`=5.
- WIDTH=12, a=17, m=3120 → `found`=1, `out`=2753. Check the latency formula against the counted k.
- WIDTH=8, a=4, m=8 → `found`=0, `out`=0. WIDTH=8, a=0, m=9 → `found`=0.
- WIDTH=8, a=10, m=7 → `out`=5. m=1 or m=0 → `found`=0, `done` exactly 2 cycles after acceptance.
- Pulse `start` with new operands while `busy` → ignored; result matches the first request. Drop `rst_n` low mid-DIV → all outputs 0 at once, no `done`. Restart with a=3, m=7 → `out`=5.
- Random sweep, WIDTH=8, all a, m < 256: `found` equals (gcd = 1 and m ≥ 2); when found, (a·out) mod m = 1 and out < m.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared RSA key-generation definitions.
// Euclid FSM states and signed-coefficient guard width.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOP,
    DIV,
    UPDATE,
    FINAL
  } state_t;

  // Bézout coefficients need WIDTH+TWX bits as signed values
  localparam int TWX = 2;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// div_done pulses WIDTH cycles after the div_start cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH:0]   part;
  logic             ge;
  logic [CW-1:0]    cnt_q;
  logic             done_q;

  // The first step runs on the start edge straight from the operands
  always_comb begin
    src_rem = div_start ? '0       : rem_q;
    src_quo = div_start ? dividend : quo_q;
    src_dvs = div_start ? divisor  : dvs_q;
    part    = {src_rem, src_quo[WIDTH-1]};
    ge      = (part >= {1'b0, src_dvs});
    rem_d   = ge ? WIDTH'(part - {1'b0, src_dvs})
                 : part[WIDTH-1:0];
    quo_d   = {src_quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (div_start) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= divisor;
      cnt_q  <= CW'(WIDTH - 1);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_done  = done_q;

endmodule

// File: rtl/mod_inverse.sv
// Modular inverse via iterative extended Euclid.
// Reports failure when gcd(a, m) != 1 or m < 2.
import rsa_pkg::*;

module mod_inverse #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] out
);

  localparam int TW = WIDTH + TWX;

  state_t state_q;

  logic [WIDTH-1:0]     r0_q, r1_q, m_q;
  logic [WIDTH-1:0]     q_q, rem_q;
  logic signed [TW-1:0] t0_q, t1_q;
  logic                 busy_q, done_q, found_q;
  logic [WIDTH-1:0]     out_q;

  logic                 m_ok, div_start, div_done;
  logic [WIDTH-1:0]     div_q, div_r;
  logic signed [TW-1:0] prod;
  logic [WIDTH-1:0]     t_pos;

  assign m_ok      = (m_q >= WIDTH'(2));
  assign div_start = (state_q == LOOP) && m_ok
                  && (r1_q != '0);

  // |t| <= m, so the product is exact modulo 2^TW
  assign prod  = $signed({2'b00, q_q}) * t1_q;
  assign t_pos = t0_q[WIDTH-1:0] + m_q;

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_start(div_start),
    .dividend (r0_q),
    .divisor  (r1_q),
    .quotient (div_q),
    .remainder(div_r),
    .div_done (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      m_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= start;
          if (start) begin
            r0_q    <= m;
            r1_q    <= a;
            m_q     <= m;
            t0_q    <= '0;
            t1_q    <= TW'(1);
            found_q <= 1'b0;
            out_q   <= '0;
            state_q <= LOOP;
          end
        end
        LOOP: begin
          if (div_start) state_q <= DIV;
          else           state_q <= FINAL;
        end
        DIV: begin
          if (div_done) begin
            q_q     <= div_q;
            rem_q   <= div_r;
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          r0_q    <= r1_q;
          r1_q    <= rem_q;
          t0_q    <= t1_q;
          t1_q    <= t0_q - prod;
          state_q <= LOOP;
        end
        FINAL: begin
          if (m_ok && r0_q == WIDTH'(1)) begin
            found_q <= 1'b1;
            out_q   <= t0_q[TW-1] ? t_pos
                                  : t0_q[WIDTH-1:0];
          end else begin
            found_q <= 1'b0;
            out_q   <= '0;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign out   = out_q;

endmodule
